// File: rtl/regfile_wb_scoreboard_pkg.sv
// Shared widths and types for the register-file write-back path and its scoreboard.
package regfile_wb_scoreboard_pkg;
   localparam int REG_W    = 5;
   localparam int XLEN     = 32;
   localparam int NUM_REGS = 32;
   localparam logic [REG_W-1:0] X0 = '0;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic [XLEN-1:0]  data;
   } wb_ent_t;
endpackage

// File: rtl/regfile_wb_scoreboard_lsu_wb_hold.sv
// One-entry holding register for LSU returns; ready depends only on its own state.
module lsu_wb_hold
   import regfile_wb_scoreboard_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   input  logic [REG_W-1:0] in_rd,
   input  logic [XLEN-1:0]  in_data,
   output logic             in_ready,
   input  logic             drain,
   output wb_ent_t          hold
);
   assign in_ready = ~hold.valid;

   // Capture and drain are mutually exclusive: drain needs a full entry, capture an empty one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold <= '0;
      end else if (drain) begin
         hold.valid <= 1'b0;
      end else if (in_valid && in_ready) begin
         hold.valid <= 1'b1;
         hold.rd    <= in_rd;
         hold.data  <= in_data;
      end
   end
endmodule

// File: rtl/regfile_wb_scoreboard.sv
// Write-back arbiter (ALU over LSU) for the register file plus the long-latency
// hazard scoreboard that stalls issue.
module regfile_wb_scoreboard
   import regfile_wb_scoreboard_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_W           = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                issue_valid,
   input  logic [REG_W-1:0]    issue_rs1,
   input  logic [REG_W-1:0]    issue_rs2,
   input  logic                issue_use_rs1,
   input  logic                issue_use_rs2,
   input  logic                issue_writes,
   input  logic [REG_W-1:0]    issue_rd,
   input  logic                issue_long,
   output logic                issue_stall,
   input  logic                alu_wb_valid,
   input  logic [REG_W-1:0]    alu_wb_rd,
   input  logic [XLEN-1:0]     alu_wb_data,
   input  logic                lsu_wb_valid,
   input  logic [REG_W-1:0]    lsu_wb_rd,
   input  logic [XLEN-1:0]     lsu_wb_data,
   output logic                lsu_wb_ready,
   output logic                rf_we,
   output logic [REG_W-1:0]    rf_wa,
   output logic [XLEN-1:0]     rf_wd,
   output logic [NUM_REGS-1:0] busy_vec,
   output logic [CNT_W-1:0]    outstanding,
   output logic                err_sticky
);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

   wb_ent_t             hold;
   logic                drain;
   logic                hz1, hz2, hzd, full, accept, set_long, dec_ok, err_set;
   logic [NUM_REGS-1:0] busy_nxt;
   logic [CNT_W-1:0]    cnt_nxt;

   lsu_wb_hold u_hold (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_valid (lsu_wb_valid),
      .in_rd    (lsu_wb_rd),
      .in_data  (lsu_wb_data),
      .in_ready (lsu_wb_ready),
      .drain    (drain),
      .hold     (hold)
   );

   // Hazards look only at registered busy bits; a same-edge clear is seen next cycle.
   assign hz1         = issue_use_rs1 & busy_vec[issue_rs1];
   assign hz2         = issue_use_rs2 & busy_vec[issue_rs2];
   assign hzd         = issue_writes & busy_vec[issue_rd];
   assign full        = issue_long & issue_writes & (outstanding == MAX_CNT);
   assign issue_stall = issue_valid & (hz1 | hz2 | hzd | full);
   assign accept      = issue_valid & ~issue_stall;
   assign set_long    = accept & issue_long & issue_writes;

   // ALU cannot be back-pressured, so the hold only drains on ALU-idle cycles.
   assign drain  = hold.valid & ~alu_wb_valid;
   assign dec_ok = drain & (outstanding != '0);
   assign err_set = drain & (((hold.rd != X0) & ~busy_vec[hold.rd]) | (outstanding == '0));

   always_comb begin
      busy_nxt = busy_vec;
      if (drain)
         busy_nxt[hold.rd] = 1'b0;
      if (set_long)
         busy_nxt[issue_rd] = 1'b1;
      busy_nxt[X0] = 1'b0;
   end

   always_comb begin
      cnt_nxt = outstanding;
      unique case ({set_long, dec_ok})
         2'b10:   cnt_nxt = outstanding + CNT_W'(1);
         2'b01:   cnt_nxt = outstanding - CNT_W'(1);
         default: cnt_nxt = outstanding;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_vec    <= '0;
         outstanding <= '0;
         err_sticky  <= 1'b0;
         rf_we       <= 1'b0;
         rf_wa       <= '0;
         rf_wd       <= '0;
      end else begin
         busy_vec    <= busy_nxt;
         outstanding <= cnt_nxt;
         if (err_set)
            err_sticky <= 1'b1;
         if (alu_wb_valid) begin
            rf_we <= (alu_wb_rd != X0);
            rf_wa <= alu_wb_rd;
            rf_wd <= alu_wb_data;
         end else if (hold.valid) begin
            rf_we <= (hold.rd != X0);
            rf_wa <= hold.rd;
            rf_wd <= hold.data;
         end else begin
            rf_we <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// traffic checked every cycle against a behavioural model.
module tb_regfile_wb_scoreboard;
   localparam int MAXO = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        issue_valid, issue_use_rs1, issue_use_rs2, issue_writes, issue_long;
   logic [4:0]  issue_rs1, issue_rs2, issue_rd;
   logic        issue_stall;
   logic        alu_wb_valid;
   logic [4:0]  alu_wb_rd;
   logic [31:0] alu_wb_data;
   logic        lsu_wb_valid;
   logic [4:0]  lsu_wb_rd;
   logic [31:0] lsu_wb_data;
   logic        lsu_wb_ready;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;
   logic [31:0] busy_vec;
   logic [3:0]  outstanding;
   logic        err_sticky;

   int checks = 0;
   int errors = 0;
   bit lsu_from_q;

   regfile_wb_scoreboard #(.MAX_OUTSTANDING(MAXO), .CNT_W(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
      .issue_writes(issue_writes), .issue_rd(issue_rd), .issue_long(issue_long),
      .issue_stall(issue_stall),
      .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
      .lsu_wb_valid(lsu_wb_valid), .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
      .lsu_wb_ready(lsu_wb_ready),
      .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
      .busy_vec(busy_vec), .outstanding(outstanding), .err_sticky(err_sticky)
   );

   always #5 clk = ~clk;

   // Behavioural model: busy set of registers, counter, and a queue of pending loads.
   logic [31:0] m_busy;
   int          m_out;
   bit          m_hv;
   logic [4:0]  m_hrd;
   logic [31:0] m_hd;
   bit          m_we;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;
   bit          m_err;
   logic [4:0]  m_pend[$];

   function automatic bit m_stall();
      return issue_valid && ((issue_use_rs1 && m_busy[issue_rs1]) ||
                             (issue_use_rs2 && m_busy[issue_rs2]) ||
                             (issue_writes && m_busy[issue_rd]) ||
                             (issue_long && issue_writes && m_out == MAXO));
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_busy = '0; m_out = 0; m_hv = 0; m_hrd = '0; m_hd = '0;
         m_we = 0; m_wa = '0; m_wd = '0; m_err = 0;
         m_pend.delete();
      end else begin : upd
         bit acc, cap, drn;
         acc = issue_valid && !m_stall();
         cap = lsu_wb_valid && !m_hv;
         drn = m_hv && !alu_wb_valid;
         if (alu_wb_valid) begin
            m_we = (alu_wb_rd != 0); m_wa = alu_wb_rd; m_wd = alu_wb_data;
         end else if (m_hv) begin
            m_we = (m_hrd != 0); m_wa = m_hrd; m_wd = m_hd;
         end else begin
            m_we = 0;
         end
         if (drn) begin
            if (m_hrd != 0 && !m_busy[m_hrd]) m_err = 1;
            if (m_out == 0) m_err = 1;
            else m_out = m_out - 1;
            m_busy[m_hrd] = 1'b0;
            m_hv = 0;
         end
         if (acc && issue_long && issue_writes) begin
            m_out = m_out + 1;
            if (issue_rd != 0) m_busy[issue_rd] = 1'b1;
            m_pend.push_back(issue_rd);
         end
         m_busy[0] = 1'b0;
         if (cap) begin
            m_hv = 1; m_hrd = lsu_wb_rd; m_hd = lsu_wb_data;
            if (lsu_from_q && m_pend.size() > 0) void'(m_pend.pop_front());
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         chk("rf_we", 32'(rf_we), 32'(m_we));
         chk("rf_wa", 32'(rf_wa), 32'(m_wa));
         chk("rf_wd", rf_wd, m_wd);
         chk("busy_vec", busy_vec, m_busy);
         chk("outstanding", 32'(outstanding), 32'(m_out));
         chk("err_sticky", 32'(err_sticky), 32'(m_err));
         #2;
         if (reset_n) begin
            chk("issue_stall", 32'(issue_stall), 32'(m_stall()));
            chk("lsu_wb_ready", 32'(lsu_wb_ready), 32'(!m_hv));
         end
      end
   end

   task automatic idle();
      issue_valid = 0; issue_use_rs1 = 0; issue_use_rs2 = 0; issue_writes = 0;
      issue_long = 0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
      alu_wb_valid = 0; alu_wb_rd = '0; alu_wb_data = '0;
      lsu_wb_valid = 0; lsu_wb_rd = '0; lsu_wb_data = '0;
      lsu_from_q = 0;
   endtask

   task automatic long_issue(input logic [4:0] rd);
      issue_valid = 1; issue_writes = 1; issue_long = 1; issue_rd = rd;
   endtask

   task automatic lsu_ret(input logic [4:0] rd, input logic [31:0] d);
      lsu_wb_valid = 1; lsu_wb_rd = rd; lsu_wb_data = d;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_we"}, 32'(rf_we), 0);
      chk({nm, "_wa"}, 32'(rf_wa), 0);
      chk({nm, "_wd"}, rf_wd, 0);
      chk({nm, "_busy"}, busy_vec, 0);
      chk({nm, "_out"}, 32'(outstanding), 0);
      chk({nm, "_err"}, 32'(err_sticky), 0);
   endtask

   initial begin
      idle();
      reset_n = 0;
      repeat (3) @(negedge clk);
      chk_zero("rst");
      reset_n = 1;
      @(negedge clk);
      chk_zero("rst_rel");

      // ALU write is visible one edge later
      alu_wb_valid = 1; alu_wb_rd = 5; alu_wb_data = 32'hDEADBEEF;
      @(negedge clk); idle();
      chk("t1_we", 32'(rf_we), 1);
      chk("t1_wa", 32'(rf_wa), 5);
      chk("t1_wd", rf_wd, 32'hDEADBEEF);
      chk("t1_busy", busy_vec, 0);

      // RAW on an in-flight load
      long_issue(7);
      @(negedge clk); idle();
      chk("t2_busy", busy_vec, 32'h80);
      issue_valid = 1; issue_use_rs1 = 1; issue_rs1 = 7;
      #1 chk("t2_stall_a", 32'(issue_stall), 1);
      @(negedge clk);
      lsu_ret(7, 32'h1234);
      #1 chk("t2_stall_b", 32'(issue_stall), 1);
      @(negedge clk); lsu_wb_valid = 0;
      chk("t2_cap_we", 32'(rf_we), 0);
      #1 chk("t2_stall_c", 32'(issue_stall), 1);
      chk("t2_ready", 32'(lsu_wb_ready), 0);
      @(negedge clk);
      chk("t2_we", 32'(rf_we), 1);
      chk("t2_wa", 32'(rf_wa), 7);
      chk("t2_wd", rf_wd, 32'h1234);
      chk("t2_busy_clr", busy_vec, 0);
      #1 chk("t2_stall_d", 32'(issue_stall), 0);
      @(negedge clk); idle();

      // Outstanding limit
      for (int r = 1; r <= 4; r++) begin
         long_issue(5'(r));
         @(negedge clk);
      end
      idle();
      chk("t3_out4", 32'(outstanding), 4);
      chk("t3_busy", busy_vec, 32'h1E);
      long_issue(5);
      #1 chk("t3_full", 32'(issue_stall), 1);
      lsu_ret(1, 32'h11);
      @(negedge clk); lsu_wb_valid = 0;
      chk("t3_out_cap", 32'(outstanding), 4);
      #1 chk("t3_full_b", 32'(issue_stall), 1);
      @(negedge clk);
      chk("t3_out3", 32'(outstanding), 3);
      chk("t3_wa", 32'(rf_wa), 1);
      #1 chk("t3_free", 32'(issue_stall), 0);
      @(negedge clk); idle();
      chk("t3_out4b", 32'(outstanding), 4);
      chk("t3_busy_b", busy_vec, 32'h3C);

      // ALU beats a held LSU return
      lsu_ret(3, 32'h33);
      @(negedge clk); lsu_wb_valid = 0;
      alu_wb_valid = 1; alu_wb_rd = 9; alu_wb_data = 32'h99;
      #1 chk("t4_ready", 32'(lsu_wb_ready), 0);
      @(negedge clk); alu_wb_valid = 0;
      chk("t4_alu_wa", 32'(rf_wa), 9);
      chk("t4_alu_wd", rf_wd, 32'h99);
      #1 chk("t4_ready_b", 32'(lsu_wb_ready), 0);
      @(negedge clk);
      chk("t4_lsu_wa", 32'(rf_wa), 3);
      chk("t4_lsu_wd", rf_wd, 32'h33);
      chk("t4_busy", busy_vec, 32'h34);
      chk("t4_out", 32'(outstanding), 3);
      foreach (m_busy[i]) ;
      for (int r = 2; r <= 5; r++) begin
         if (r == 3) continue;
         lsu_ret(5'(r), 32'(r));
         @(negedge clk); lsu_wb_valid = 0;
         @(negedge clk);
      end
      chk("t4_out0", 32'(outstanding), 0);
      chk("t4_busy0", busy_vec, 0);

      // Long write to x0
      long_issue(0);
      @(negedge clk); idle();
      chk("t5_busy", busy_vec, 0);
      chk("t5_out", 32'(outstanding), 1);
      lsu_ret(0, 32'h55);
      @(negedge clk); lsu_wb_valid = 0;
      @(negedge clk);
      chk("t5_we", 32'(rf_we), 0);
      chk("t5_out0", 32'(outstanding), 0);
      chk("t5_err", 32'(err_sticky), 0);

      // Stray return, then reset with the hold occupied
      lsu_ret(12, 32'hC);
      @(negedge clk); lsu_wb_valid = 0;
      @(negedge clk);
      chk("t6_err", 32'(err_sticky), 1);
      lsu_ret(13, 32'hD);
      @(negedge clk); lsu_wb_valid = 0;
      #1 reset_n = 0;
      #1 chk_zero("t6_rst");
      repeat (2) @(negedge clk);
      reset_n = 1;

      repeat (3000) begin
         @(negedge clk);
         issue_valid   = ($urandom % 10) < 6;
         issue_rs1     = 5'($urandom % 8);
         issue_rs2     = 5'($urandom % 8);
         issue_rd      = 5'($urandom % 8);
         issue_use_rs1 = $urandom % 2;
         issue_use_rs2 = $urandom % 2;
         issue_writes  = ($urandom % 10) < 7;
         issue_long    = $urandom % 2;
         alu_wb_valid  = ($urandom % 10) < 3;
         alu_wb_rd     = 5'($urandom % 32);
         alu_wb_data   = $urandom;
         lsu_wb_data   = $urandom;
         if (m_pend.size() > 0 && ($urandom % 3) == 0) begin
            lsu_wb_valid = 1; lsu_wb_rd = m_pend[0]; lsu_from_q = 1;
         end else if (($urandom % 64) == 0) begin
            lsu_wb_valid = 1; lsu_wb_rd = 5'($urandom % 32); lsu_from_q = 0;
         end else begin
            lsu_wb_valid = 0; lsu_from_q = 0;
         end
      end
      @(negedge clk); idle();
      @(negedge clk);
      #3;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/regfile_wb_scoreboard.md
Name: regfile_wb_scoreboard

Overview:
Write-back controller and hazard scoreboard for the 32x32 register file.
- Merges the single-cycle ALU result path and the variable-latency LSU (load) return path onto the register file's single write port.
- Tracks which architectural registers have a long-latency write in flight, and stalls the issue stage on RAW/WAW hazards against them.
- Sits between execute/LSU and the register file write port; drives the issue-stage stall.

Parameters:
MAX_OUTSTANDING, 4, maximum in-flight long-latency (load) writes; legal range 1..15.
CNT_W, 4, outstanding counter width; must satisfy 2^CNT_W > MAX_OUTSTANDING.

Ports:
clk  in  1  clock, all state on rising edge.
reset_n  in  1  asynchronous active-low reset.
issue_valid  in  1  decode stage presents an instruction.
issue_rs1  in  5  source register 1.
issue_rs2  in  5  source register 2.
issue_use_rs1  in  1  instruction reads rs1.
issue_use_rs2  in  1  instruction reads rs2.
issue_writes  in  1  instruction writes rd.
issue_rd  in  5  destination register.
issue_long  in  1  rd is written through the LSU return path.
issue_stall  out  1  combinational; hold decode this cycle.
alu_wb_valid  in  1  ALU result valid; cannot be back-pressured.
alu_wb_rd  in  5  ALU destination.
alu_wb_data  in  32  ALU result.
lsu_wb_valid  in  1  LSU return valid.
lsu_wb_rd  in  5  LSU destination.
lsu_wb_data  in  32  LSU return data.
lsu_wb_ready  out  1  LSU return accepted when valid & ready.
rf_we  out  1  register file write enable (registered).
rf_wa  out  5  register file write address (registered).
rf_wd  out  32  register file write data (registered).
busy_vec  out  32  registered scoreboard; bit 0 is always 0.
outstanding  out  CNT_W  in-flight long writes.
err_sticky  out  1  LSU return to a non-busy register was seen.

Behaviour:
- Reset (async, reset_n=0) clears: busy_vec, outstanding, hold buffer, rf_we, rf_wa, rf_wd, err_sticky. All are 0 while reset is held and in the first cycle after release.
- issue_stall = issue_valid & (hz1 | hz2 | hzd | full).
  - hz1 = use_rs1 & busy[rs1].
  - hz2 = use_rs2 & busy[rs2].
  - hzd = writes & busy[rd].
  - full = long & writes & (outstanding == MAX_OUTSTANDING).
  - Uses registered busy_vec only; there is no same-cycle clear bypass.
- accept = issue_valid & ~issue_stall.
- On accept with long & writes & rd!=0: set busy[rd] and increment outstanding. When rd==0, increment outstanding only.
- LSU hold buffer (one entry: valid, rd, data):
  - lsu_wb_ready = ~hold_valid (registered-state only; no combinational path from LSU valid).
  - Capture on lsu_wb_valid & lsu_wb_ready.
- Write-port arbitration each cycle, ALU has fixed priority:
  - alu_wb_valid: the next edge loads rf_we=(alu_wb_rd!=0), rf_wa/rf_wd=ALU; hold waits.
  - else hold_valid: the next edge loads rf_we=(hold_rd!=0), rf_wa/rf_wd=hold. Drain hold: clear busy[hold_rd] and decrement outstanding.
  - else rf_we=0; rf_wa/rf_wd keep their value.
- Write latency: 1 cycle from the ALU input to rf_we. For LSU, the minimum is 2 cycles (capture, then drain).
- The busy clear and the rf write are registered on the same edge. The register file's internal write bypass covers a read in that cycle.
- Simultaneous cases:
  - Drain and long-issue on the same edge: outstanding is unchanged.
  - Drain of reg R and an issue setting R cannot coexist (hzd stalls). If forced, set wins.
  - Capture and drain on the same edge cannot occur (ready=0 while hold is full).
- Draining a register whose busy bit is 0, with rd!=0, sets err_sticky (cleared only by reset). outstanding never underflows: a decrement at 0 is suppressed and also sets err_sticky.
- Reset mid-operation drops in-flight state. The LSU must also be reset.

Decomposition:
- Shared package: register index width (5), XLEN (32), and the x0 index constant.
- Natural sub-module: lsu_wb_hold, the one-entry valid/ready holding register. The scoreboard, counter and arbiter stay in the top.

Test Plan:
1. Reset, then ALU write rd=5 data=0xDEADBEEF → next cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF; busy_vec=0.
2. Long issue rd=7, then issue using rs1=7 → issue_stall=1 until the LSU returns rd=7 data=0x1234. Then rf write of 0x1234 occurs 2 cycles after the return, busy[7] clears on the same edge, and the stall drops the following cycle.
3. Issue 4 long writes to rd=1..4 (outstanding=4); a 5th long issue stalls. One drain → outstanding=3 and the 5th issues.
4. ALU write rd=9 on the same cycle the hold holds rd=3 → rd=9 written first and lsu_wb_ready stays 0. rd=3 is written the next cycle.
5. Long issue rd=0 → no busy bit set, outstanding=1. LSU return rd=0 → rf_we=0, outstanding=0, err_sticky=0.
6. LSU return rd=12 with busy[12]=0 → err_sticky=1. Assert reset_n=0 mid-hold → all outputs 0 immediately.
